// File: rtl/controlador_boot_if.sv
// controlador_boot_if: source-word handshake and instruction-memory write port of the boot sequencer.
interface controlador_boot_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    modport master (output src_valid, src_data, input src_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input src_valid, src_data, output src_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/controlador_boot.sv
// controlador_boot: BIOS -> program copy into imem -> CPU reset pulse -> execute from imem.
// Define BOOT_TIMEOUT_EN to add the per-beat stall timeout and the S_FAULT state.
module controlador_boot #(
    parameter int                DATA_W      = 32,
    parameter int                ADDR_W      = 10,
    parameter logic [5:0]        HALT_OP     = 6'b011000,
    parameter logic [DATA_W-1:0] NOP_INSTR   = 32'h4000_0000,
    parameter int                RESET_CYC   = 2,
    parameter int                TIMEOUT_CYC = 1024
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    controlador_boot_if.slave bus,
    input  logic [DATA_W-1:0] mem_i,
    input  logic [DATA_W-1:0] bios_i,
    input  logic [ADDR_W:0]   prog_len_i,
    input  logic              reboot_i,
    output logic [DATA_W-1:0] instrucao_o,
    output logic              cpu_reset_o,
    output logic              is_bios_o,
    output logic              is_transf_o,
    output logic              fault_o
);
    typedef enum logic [2:0] {S_BIOS, S_TRANSF, S_RST, S_EXEC `ifdef BOOT_TIMEOUT_EN , S_FAULT `endif} state_t;
    localparam int              RW       = RESET_CYC > 1 ? $clog2(RESET_CYC) : 1;
    localparam logic [RW-1:0]   RST_INIT = RW'(RESET_CYC - 1);
    localparam logic [ADDR_W:0] MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};
    state_t            state_q, target_q;
    logic [ADDR_W:0]   cnt_q, len_q;
    logic [RW-1:0]     rst_cnt_q;
    logic              beat, halt;
`ifdef BOOT_TIMEOUT_EN
    localparam int     SW = $clog2(TIMEOUT_CYC + 1);
    logic [SW-1:0]     stall_q;
    assign fault_o = state_q == S_FAULT;
`else
    assign fault_o = 1'b0;
`endif
    assign halt           = bios_i[DATA_W-1 -: 6] == HALT_OP;
    assign bus.src_ready  = state_q == S_TRANSF && cnt_q < len_q;
    assign beat           = bus.src_valid && bus.src_ready;
    assign bus.imem_we    = beat;
    assign bus.imem_addr  = cnt_q[ADDR_W-1:0];
    assign bus.imem_wdata = bus.src_data;
    assign instrucao_o    = state_q == S_BIOS ? bios_i : state_q == S_EXEC ? mem_i : NOP_INSTR;
    assign cpu_reset_o    = state_q == S_RST;
    assign is_bios_o      = state_q == S_BIOS;
    assign is_transf_o    = state_q == S_TRANSF;
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q   <= S_BIOS;
            target_q  <= S_BIOS;
            cnt_q     <= '0;
            len_q     <= '0;
            rst_cnt_q <= '0;
`ifdef BOOT_TIMEOUT_EN
            stall_q   <= '0;
`endif
        end else begin
            case (state_q)
                S_BIOS: if (halt) begin
                    len_q     <= prog_len_i > MAX_LEN ? MAX_LEN : prog_len_i;
                    cnt_q     <= '0;
                    rst_cnt_q <= RST_INIT;
                    target_q  <= S_EXEC;
                    state_q   <= prog_len_i == '0 ? S_RST : S_TRANSF;
`ifdef BOOT_TIMEOUT_EN
                    stall_q   <= '0;
`endif
                end
                S_TRANSF: begin
                    if (beat) cnt_q <= cnt_q + 1'b1;
                    // an abandoned transfer still commits the beat of the reboot cycle
                    if (reboot_i) begin
                        state_q   <= S_RST;
                        target_q  <= S_BIOS;
                        rst_cnt_q <= RST_INIT;
                        cnt_q     <= '0;
                    end else if (beat && cnt_q == len_q - 1'b1) begin
                        state_q   <= S_RST;
                        target_q  <= S_EXEC;
                        rst_cnt_q <= RST_INIT;
                    end
`ifdef BOOT_TIMEOUT_EN
                    else if (!beat && stall_q == SW'(TIMEOUT_CYC - 1)) state_q <= S_FAULT;
                    stall_q <= beat ? '0 : stall_q + 1'b1;
`endif
                end
                S_RST: if (rst_cnt_q == '0) state_q <= target_q; else rst_cnt_q <= rst_cnt_q - 1'b1;
                S_EXEC: if (reboot_i) begin
                    state_q   <= S_RST;
                    target_q  <= S_BIOS;
                    rst_cnt_q <= RST_INIT;
                    cnt_q     <= '0;
                end
`ifdef BOOT_TIMEOUT_EN
                S_FAULT: if (reboot_i) begin
                    state_q   <= S_RST;
                    target_q  <= S_BIOS;
                    rst_cnt_q <= RST_INIT;
                end
`endif
                default: state_q <= S_BIOS;
            endcase
        end
    end
endmodule

// File: tb/tb_controlador_boot.sv
// tb_controlador_boot: randomized boot sequences; expected imem writes queued from the program image, checked by a monitor.
module tb_controlador_boot;
    localparam int          DW = 32, AW = 4, RC = 2, TC = 8;
    localparam int          MAXW = 1 << AW;
    localparam logic [31:0] NOP = 32'h4000_0000;
    localparam logic [31:0] ADD_W = 32'h0412_3456;
    localparam logic [31:0] HALT_W = {6'b011000, 26'h0000abc};
    logic clk = 0, rst_n = 0;
    logic [DW-1:0] mem, bios, instrucao;
    logic [AW:0] prog_len;
    logic reboot, cpu_reset, is_bios, is_transf, fault;
    int n_cmp = 0, n_bad = 0;
    logic [AW-1:0] exp_a[$];
    logic [DW-1:0] exp_d[$];
    controlador_boot_if #(.DATA_W(DW), .ADDR_W(AW)) bus();
    controlador_boot #(.DATA_W(DW), .ADDR_W(AW), .RESET_CYC(RC), .TIMEOUT_CYC(TC)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .bus(bus), .mem_i(mem), .bios_i(bios),
        .prog_len_i(prog_len), .reboot_i(reboot), .instrucao_o(instrucao),
        .cpu_reset_o(cpu_reset), .is_bios_o(is_bios), .is_transf_o(is_transf), .fault_o(fault));
    always #5 clk = ~clk;
    function automatic void chk(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endfunction
    always @(negedge clk) if (rst_n && bus.imem_we) begin
        if (exp_a.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected no write", bus.imem_addr, bus.imem_wdata);
        end else begin
            chk("write_addr", 64'(bus.imem_addr), 64'(exp_a.pop_front()));
            chk("write_data", 64'(bus.imem_wdata), 64'(exp_d.pop_front()));
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_then(input bit to_bios);
        int n = 0;
        bit done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (cpu_reset) begin
                n++;
                if (n == 1) chk("rst_instr", 64'(instrucao), 64'(NOP));
            end else done = 1;
        end
        chk("rst_len", 64'(n), 64'(RC));
        if (to_bios) begin
            chk("bios_flag", 64'(is_bios), 64'd1);
            chk("bios_instr", 64'(instrucao), 64'(bios));
            chk("bios_fault", 64'(fault), 64'd0);
        end else begin
            chk("exec_instr", 64'(instrucao), 64'(mem));
            chk("exec_isbios", 64'(is_bios), 64'd0);
            chk("exec_ready", 64'(bus.src_ready), 64'd0);
        end
        tick();
    endtask
    task automatic do_reboot;
        reboot = 1;
        tick();
        reboot = 0;
        pulse_then(1);
    endtask
    // mode 0: valid always, 1: valid toggles, 2: random valid; abort_at >= 0 reboots on that beat
    task automatic run_boot(input int len, input int mode, input int abort_at);
        int eff = len > MAXW ? MAXW : len;
        int i = 0, cyc = 0;
        bit ph = 1, ab = 0;
        logic [DW-1:0] d[$];
        for (int k = 0; k < eff; k++) d.push_back($urandom);
        for (int k = 0; k <= (abort_at >= 0 ? abort_at : eff - 1); k++) begin
            exp_a.push_back(AW'(k));
            exp_d.push_back(d[k]);
        end
        mem = $urandom;
        bios = HALT_W;
        prog_len = (AW+1)'(len);
        tick();
        bios = ADD_W;
        prog_len = (AW+1)'($urandom);
        while (i < eff && !ab && cyc < 200) begin
            bus.src_valid = mode == 0 ? 1'b1 : mode == 1 ? ph : 1'($urandom_range(0, 1));
            bus.src_data = bus.src_valid ? d[i] : $urandom;
            reboot = bus.src_valid && i == abort_at;
            ph = !ph;
            @(negedge clk);
            if (cyc == 0) chk("is_transf", 64'(is_transf), 64'd1);
            if (bus.src_valid && bus.src_ready) begin
                ab = reboot;
                i++;
            end
            cyc++;
            tick();
        end
        bus.src_valid = 0;
        reboot = 0;
        if (!ab) chk("beats_done", 64'(i), 64'(eff));
        if (mode == 0 && abort_at < 0) chk("transf_cycles", 64'(cyc), 64'(eff));
        pulse_then(ab);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
    initial begin
        int ab, ln;
        bus.src_valid = 0;
        bus.src_data = 0;
        reboot = 0;
        mem = 0;
        bios = ADD_W;
        prog_len = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_instr_bios", 64'(instrucao), 64'(ADD_W));
        chk("rst_isbios", 64'(is_bios), 64'd1);
        chk("rst_cpu_reset", 64'(cpu_reset), 64'd0);
        chk("rst_src_ready", 64'(bus.src_ready), 64'd0);
        chk("rst_fault", 64'(fault), 64'd0);
        tick();
        reboot = 1;
        repeat (2) begin
            @(negedge clk);
            chk("bios_reboot_ignored", 64'(is_bios), 64'd1);
            chk("bios_no_reset", 64'(cpu_reset), 64'd0);
        end
        tick();
        reboot = 0;
        run_boot(4, 0, -1);
        mem = HALT_W;
        tick();
        @(negedge clk);
        chk("exec_halt_ignored", 64'(instrucao), 64'(HALT_W));
        chk("exec_halt_no_reset", 64'(cpu_reset), 64'd0);
        tick();
        do_reboot();
        run_boot(4, 1, -1);
        do_reboot();
        run_boot(0, 0, -1);
        do_reboot();
        run_boot(20, 0, -1);
        do_reboot();
        run_boot(8, 2, 3);
        run_boot(5, 2, -1);
        do_reboot();
        for (int r = 0; r < 6; r++) begin
            ln = $urandom_range(0, 18);
            ab = ($urandom_range(0, 2) == 0 && ln > 1) ? $urandom_range(0, (ln > MAXW ? MAXW : ln) - 1) : -1;
            run_boot(ln, $urandom_range(0, 2), ab);
            if (ab < 0) do_reboot();
        end
`ifdef BOOT_TIMEOUT_EN
        begin
            int n = 0;
            bit hit = 0;
            for (int k = 0; k < 2; k++) begin
                exp_a.push_back(AW'(k));
                exp_d.push_back(32'hB0 + k);
            end
            bios = HALT_W;
            prog_len = 4;
            tick();
            bios = ADD_W;
            for (int k = 0; k < 2; k++) begin
                bus.src_valid = 1;
                bus.src_data = 32'hB0 + k;
                tick();
            end
            bus.src_valid = 0;
            for (int c = 0; c < 40 && !hit; c++) begin
                @(negedge clk);
                if (fault) hit = 1;
                else begin
                    n++;
                    tick();
                end
            end
            chk("stall_cycles", 64'(n), 64'(TC));
            chk("fault_ready", 64'(bus.src_ready), 64'd0);
            chk("fault_instr", 64'(instrucao), 64'(NOP));
            tick();
            do_reboot();
        end
`endif
        chk("queue_empty", 64'(exp_a.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
